// File: rtl/dmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_pkg : shared funct3/opcode constants, FSM states and legality check
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] MEMLOAD = 7'b0000011;
    localparam logic [6:0] MEMSAVE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width/sign encoding and natural alignment; the array bound is checked by the user.
    function automatic logic legal_access(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo,
                                          input logic       is_store);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !is_store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_lane_fmt : little-endian load extract/extend and store byte merge
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (byte_off)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = 8'h00;
        endcase
        sel_half = byte_off[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            F3_W:    load_data = word;
            default: load_data = 32'h0000_0000;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (byte_off)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            F3_H: begin
                if (byte_off[1]) store_word[31:16] = wdata[15:0];
                else             store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : MEM-stage data memory with wait states, stall and error
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t         state, next_state;
    logic [3:0]     counter;
    logic [IW+1:0]  addr_q;
    logic [2:0]     funct3_q;
    logic [31:0]    wdata_q;
    logic           is_store_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           req, req_bad, accept, access;
    logic [IW+1:0]  acc_addr;
    logic [2:0]     acc_f3;
    logic [31:0]    acc_wdata;
    logic           acc_store;
    logic [31:0]    load_data, store_word;

    assign req     = mem_read_i || mem_write_i;
    assign req_bad = (mem_read_i && mem_write_i)
                   || !legal_access(funct3_i, addr_i[1:0], mem_write_i)
                   || (addr_i[31:2] >= 30'(DEPTH_WORDS));

    // With zero wait states the access happens on the accepting edge, so use live inputs.
    assign acc_addr  = (state == IDLE) ? addr_i[IW+1:0] : addr_q;
    assign acc_f3    = (state == IDLE) ? funct3_i       : funct3_q;
    assign acc_wdata = (state == IDLE) ? wdata_i        : wdata_q;
    assign acc_store = (state == IDLE) ? mem_write_i    : is_store_q;

    dmem_lane_fmt u_fmt (
        .word       (mem[acc_addr[IW+1:2]]),
        .byte_off   (acc_addr[1:0]),
        .funct3     (acc_f3),
        .wdata      (acc_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        next_state = state;
        stall_o    = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    if (req_bad) begin
                        next_state = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (counter == 4'd0) begin
                    access     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= 4'd0;
            addr_q     <= '0;
            funct3_q   <= 3'b000;
            wdata_q    <= 32'h0;
            is_store_q <= 1'b0;
            rdata_o    <= 32'h0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state  <= next_state;
            done_o <= (next_state == RESP);
            err_o  <= accept && req_bad;
            if (accept) begin
                addr_q     <= addr_i[IW+1:0];
                funct3_q   <= funct3_i;
                wdata_q    <= wdata_i;
                is_store_q <= mem_write_i;
            end
            if (accept && !req_bad && WAIT_CYCLES != 0)
                counter <= 4'(WAIT_CYCLES - 1);
            else if (state == WAIT && counter != 4'd0)
                counter <= counter - 4'd1;
            if (access)
                rdata_o <= acc_store ? 32'h0 : load_data;
            else if (accept || state == RESP)
                rdata_o <= 32'h0;
        end
    end

    // Array is deliberately left out of reset; rst_n gating blocks writes while held in reset.
    always_ff @(posedge clk) begin
        if (access && acc_store && rst_n)
            mem[acc_addr[IW+1:2]] <= store_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : directed bench for a 2-wait-state and a 0-wait-state build
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [2:0]  f3_2 = 3'b0;
    logic [31:0] a2 = 32'h0, wd2 = 32'h0;
    logic [31:0] rdata2;
    logic        done2, err2, stall2;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [2:0]  f3_0 = 3'b0;
    logic [31:0] a0 = 32'h0, wd0 = 32'h0;
    logic [31:0] rdata0;
    logic        done0, err0, stall0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_i(rd2), .mem_write_i(wr2), .funct3_i(f3_2),
        .addr_i(a2), .wdata_i(wd2),
        .rdata_o(rdata2), .done_o(done2), .err_o(err2), .stall_o(stall2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .mem_read_i(rd0), .mem_write_i(wr0), .funct3_i(f3_0),
        .addr_i(a0), .wdata_i(wd0),
        .rdata_o(rdata0), .done_o(done0), .err_o(err0), .stall_o(stall0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rd2 = 1'b0; wr2 = 1'b0; f3_2 = 3'b0; a2 = 32'h0; wd2 = 32'h0;
        rd0 = 1'b0; wr0 = 1'b0; f3_0 = 3'b0; a0 = 32'h0; wd0 = 32'h0;
    endtask

    // Issue one request and follow it to done_o, checking latency, stall shape and result.
    task automatic op(input string tag, input bit fast, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        int          lat;
        logic [31:0] got_data;
        logic        got_err;
        logic        stall_ok;
        lat = -1; got_data = 32'hx; got_err = 1'bx;
        @(negedge clk);
        if (fast) begin rd0 = rd; wr0 = wr; f3_0 = f3; a0 = a; wd0 = wd; end
        else      begin rd2 = rd; wr2 = wr; f3_2 = f3; a2 = a; wd2 = wd; end
        #1;
        stall_ok = fast ? stall0 : stall2;
        @(posedge clk);
        #1;
        clear_inputs();
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (fast ? done0 : done2) begin
                lat      = c;
                got_data = fast ? rdata0 : rdata2;
                got_err  = fast ? err0 : err2;
                if (fast ? stall0 : stall2) stall_ok = 1'b0;
            end else if (!(fast ? stall0 : stall2)) begin
                stall_ok = 1'b0;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".stall"}, {31'b0, stall_ok}, 32'd1);
        check({tag, ".rdata"}, got_data, exp_data);
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.rdata", rdata2, 32'h0);
        check("reset.done",  {31'b0, done2},  32'd0);
        check("reset.err",   {31'b0, err2},   32'd0);
        check("reset.stall", {31'b0, stall2}, 32'd0);
        check("reset.done0", {31'b0, done0},  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // word store then load, 2 wait states
        op("sw10",  0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);
        op("lw10",  0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 32'hDEADBEEF, 1'b0);

        // byte merge and sign/zero extension
        op("sb13",  0, 0, 1, 3'b000, 32'h13, 32'h00000080, 3, 32'h0, 1'b0);
        op("lb13",  0, 1, 0, 3'b000, 32'h13, 32'h0,        3, 32'hFFFFFF80, 1'b0);
        op("lbu13", 0, 1, 0, 3'b100, 32'h13, 32'h0,        3, 32'h00000080, 1'b0);
        op("lw10b", 0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 32'h80ADBEEF, 1'b0);

        // misaligned accesses error out immediately
        op("lh11",  0, 1, 0, 3'b001, 32'h11, 32'h0,        1, 32'h0, 1'b1);
        op("sw12",  0, 0, 1, 3'b010, 32'h12, 32'h55555555, 1, 32'h0, 1'b1);
        op("lw10c", 0, 1, 0, 3'b010, 32'h10, 32'h0,        3, 32'h80ADBEEF, 1'b0);

        // read+write together, out-of-range word and bad funct3
        op("sw20",  0, 0, 1, 3'b010, 32'h20, 32'h11112222, 3, 32'h0, 1'b0);
        op("rw20",  0, 1, 1, 3'b010, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
        op("lwoor", 0, 1, 0, 3'b010, 32'h400, 32'h0,       1, 32'h0, 1'b1);
        op("sbuf3", 0, 0, 1, 3'b100, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
        op("lw20",  0, 1, 0, 3'b010, 32'h20, 32'h0,        3, 32'h11112222, 1'b0);

        // reset during the first WAIT cycle aborts the store
        op("sw40",  0, 0, 1, 3'b010, 32'h40, 32'h0BADF00D, 3, 32'h0, 1'b0);
        @(negedge clk);
        rd2 = 1'b0; wr2 = 1'b1; f3_2 = 3'b010; a2 = 32'h40; wd2 = 32'h12345678;
        @(posedge clk);
        #1;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check("abort.rdata", rdata2, 32'h0);
        check("abort.done",  {31'b0, done2},  32'd0);
        check("abort.err",   {31'b0, err2},   32'd0);
        check("abort.stall", {31'b0, stall2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen_done;
            seen_done = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (done2) seen_done = 1'b1;
            end
            check("abort.nodone", {31'b0, seen_done}, 32'd0);
        end
        op("lw40",  0, 1, 0, 3'b010, 32'h40, 32'h0,        3, 32'h0BADF00D, 1'b0);

        // zero-wait-state build
        op("sh22f",  1, 0, 1, 3'b001, 32'h22, 32'h0000ABCD, 1, 32'h0, 1'b0);
        op("lhu22f", 1, 1, 0, 3'b101, 32'h22, 32'h0,        1, 32'h0000ABCD, 1'b0);
        op("lh22f",  1, 1, 0, 3'b001, 32'h22, 32'h0,        1, 32'hFFFFABCD, 1'b0);
        op("lh21f",  1, 1, 0, 3'b001, 32'h21, 32'h0,        1, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
